lsu_mem_stage: RTL and testbench



---
 rtl/lsu_mem_stage.sv | 149 ++++++++++++++
 tb/tb_lsu_mem_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_stage.sv
// RV32I load/store stage: loads and SW take 1 cycle, SB/SH do a 2-cycle read-modify-write that drops req_ready_o.
// LSU_MISALIGN_TRAP_EN: defined = misaligned ops trap (misalign_o/badaddr_o); undefined = low address bits are masked.
module lsu_mem_stage #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_100MHz,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [2:0]    req_funct3_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          ram_rena_o,
    output logic [AW-1:0] ram_raddr_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic          ram_wena_o,
    output logic [AW-1:0] ram_waddr_o,
    output logic [DW-1:0] ram_wdata_o,
    output logic          load_valid_o,
    output logic [DW-1:0] load_data_o,
    output logic          misalign_o,
    output logic [AW-1:0] badaddr_o
);

    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] word_addr;
    logic [AW-1:0] rmw_addr;
    logic [DW-1:0] rmw_data;
    logic          is_byte, is_half, is_word;
    logic          op_ok, mis, accept, do_op;
    logic [1:0]    lane;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [DW-1:0] ext_data, merged;

    assign word_addr = {req_addr_i[AW-1:2], 2'b00};

    always_comb begin
        is_byte = (req_funct3_i[1:0] == 2'b00);
        is_half = (req_funct3_i[1:0] == 2'b01);
        is_word = (req_funct3_i[1:0] == 2'b10);
        // stores only have SB/SH/SW; loads reject 011/110/111
        if (req_we_i)
            op_ok = !req_funct3_i[2] && (req_funct3_i[1:0] != 2'b11);
        else
            op_ok = (req_funct3_i[1:0] != 2'b11) && (req_funct3_i != 3'b110);
`ifdef LSU_MISALIGN_TRAP_EN
        mis  = (is_half && req_addr_i[0]) || (is_word && (req_addr_i[1:0] != 2'b00));
        lane = req_addr_i[1:0];
`else
        mis  = 1'b0;
        if (is_half)
            lane = {req_addr_i[1], 1'b0};
        else if (is_word)
            lane = 2'b00;
        else
            lane = req_addr_i[1:0];
`endif
    end

    always_comb begin
        rbyte  = ram_rdata_i[{lane, 3'b000} +: 8];
        rhalf  = ram_rdata_i[{lane[1], 4'b0000} +: 16];
        ext_data = ram_rdata_i;
        if (is_byte)
            ext_data = {{24{rbyte[7] & ~req_funct3_i[2]}}, rbyte};
        else if (is_half)
            ext_data = {{16{rhalf[15] & ~req_funct3_i[2]}}, rhalf};
        merged = ram_rdata_i;
        if (is_byte)
            merged[{lane, 3'b000} +: 8] = req_wdata_i[7:0];
        else
            merged[{lane[1], 4'b0000} +: 16] = req_wdata_i[15:0];
    end

    always_comb begin
        state_nxt   = state;
        req_ready_o = !rst && (state == IDLE);
        accept      = req_valid_i && req_ready_o;
        do_op       = accept && op_ok && !mis;
        ram_rena_o  = 1'b0;
        ram_wena_o  = 1'b0;
        ram_raddr_o = word_addr;
        ram_waddr_o = word_addr;
        ram_wdata_o = req_wdata_i;
        case (state)
            IDLE: begin
                if (do_op) begin
                    if (!req_we_i) begin
                        ram_rena_o = 1'b1;
                    end else if (is_word) begin
                        ram_wena_o = 1'b1;
                    end else begin
                        ram_rena_o = 1'b1;
                        state_nxt  = RMW_WR;
                    end
                end
            end
            RMW_WR: begin
                // reset in this cycle aborts the pending partial write
                ram_wena_o  = !rst;
                ram_waddr_o = rmw_addr;
                ram_wdata_o = rmw_data;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state        <= IDLE;
            load_valid_o <= 1'b0;
            load_data_o  <= '0;
            rmw_addr     <= '0;
            rmw_data     <= '0;
        end else begin
            state        <= state_nxt;
            load_valid_o <= do_op && !req_we_i;
            if (do_op && !req_we_i)
                load_data_o <= ext_data;
            if (state == IDLE && do_op && req_we_i && !is_word) begin
                rmw_addr <= word_addr;
                rmw_data <= merged;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            misalign_o <= 1'b0;
            badaddr_o  <= '0;
        end else begin
            misalign_o <= accept && op_ok && mis;
            if (accept && op_ok && mis)
                badaddr_o <= req_addr_i;
        end
    end
`else
    assign misalign_o = 1'b0;
    assign badaddr_o  = '0;
`endif

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: load table plus RMW, store/load, misalign, reset-abort and no-op sequences.
module tb_lsu_mem_stage;

    logic        clk_100MHz = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        ram_rena_o, ram_wena_o;
    logic [31:0] ram_raddr_o, ram_rdata_i, ram_waddr_o, ram_wdata_o;
    logic        load_valid_o, misalign_o;
    logic [31:0] load_data_o, badaddr_o;

    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_idx;
    logic [31:0] pre_dat;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q [$];

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [9];

    always #5 clk_100MHz = ~clk_100MHz;

    lsu_mem_stage #(.AW(32), .DW(32)) dut (
        .clk_100MHz   (clk_100MHz),
        .rst          (rst),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .ram_rena_o   (ram_rena_o),
        .ram_raddr_o  (ram_raddr_o),
        .ram_rdata_i  (ram_rdata_i),
        .ram_wena_o   (ram_wena_o),
        .ram_waddr_o  (ram_waddr_o),
        .ram_wdata_o  (ram_wdata_o),
        .load_valid_o (load_valid_o),
        .load_data_o  (load_data_o),
        .misalign_o   (misalign_o),
        .badaddr_o    (badaddr_o)
    );

    assign ram_rdata_i = mem[ram_raddr_o[7:2]];

    always @(posedge clk_100MHz) begin
        if (ram_wena_o)
            mem[ram_waddr_o[7:2]] <= ram_wdata_o;
        else if (pre_we)
            mem[pre_idx] <= pre_dat;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic poke(input logic [5:0] idx, input logic [31:0] dat);
        pre_we  = 1'b1;
        pre_idx = idx;
        pre_dat = dat;
        tick();
        pre_we  = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_funct3_i = f3;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
    endtask

    // scoreboard: every load result the DUT presents must match the oldest expectation
    always @(negedge clk_100MHz) begin
        if (load_valid_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL load_unexpected: got load_valid data %h expected none", load_data_o);
            end else begin
                check("load_data", load_data_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_w8;
        rst = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b000;
        req_addr_i = '0; req_wdata_i = '0;
        pre_we = 1'b0; pre_idx = '0; pre_dat = '0;

        vecs[0] = '{3'b000, 32'h13, 32'hFFFFFF80};
        vecs[1] = '{3'b100, 32'h13, 32'h00000080};
        vecs[2] = '{3'b001, 32'h12, 32'hFFFF80FF};
        vecs[3] = '{3'b101, 32'h12, 32'h000080FF};
        vecs[4] = '{3'b000, 32'h11, 32'h0000007F};
        vecs[5] = '{3'b000, 32'h12, 32'hFFFFFFFF};
        vecs[6] = '{3'b010, 32'h10, 32'h80FF7F01};
        vecs[7] = '{3'b001, 32'h10, 32'h00007F01};
        vecs[8] = '{3'b100, 32'h10, 32'h00000001};

        repeat (2) tick();
        drive(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk_100MHz);
        check("rst_ready", {31'b0, req_ready_o}, 32'd0);
        check("rst_rena", {31'b0, ram_rena_o}, 32'd0);
        check("rst_wena", {31'b0, ram_wena_o}, 32'd0);
        check("rst_load_valid", {31'b0, load_valid_o}, 32'd0);
        check("rst_load_data", load_data_o, 32'd0);
        check("rst_misalign", {31'b0, misalign_o}, 32'd0);
        check("rst_badaddr", badaddr_o, 32'd0);
        @(posedge clk_100MHz); #1;
        req_valid_i = 1'b0;
        rst = 1'b0;
        poke(6'd4, 32'h80FF7F01);
        @(negedge clk_100MHz);
        check("idle_ready", {31'b0, req_ready_o}, 32'd1);
        tick();

        // back-to-back loads from the table
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, vecs[i].f3, vecs[i].addr, 32'h0);
            exp_q.push_back(vecs[i].exp);
            @(negedge clk_100MHz);
            check("tbl_rena", {31'b0, ram_rena_o}, 32'd1);
            check("tbl_raddr", ram_raddr_o, 32'h10);
            check("tbl_wena", {31'b0, ram_wena_o}, 32'd0);
            tick();
        end
        req_valid_i = 1'b0;
        tick(); tick();
        check("tbl_drained", exp_q.size(), 32'd0);

        // SB read-modify-write, with a LW held during the write cycle
        poke(6'd4, 32'h11223344);
        drive(1'b1, 3'b000, 32'h11, 32'h000000AB);
        @(negedge clk_100MHz);
        check("sb_ready", {31'b0, req_ready_o}, 32'd1);
        check("sb_rena", {31'b0, ram_rena_o}, 32'd1);
        check("sb_wena_rd", {31'b0, ram_wena_o}, 32'd0);
        tick();
        drive(1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk_100MHz);
        check("rmw_ready", {31'b0, req_ready_o}, 32'd0);
        check("rmw_rena", {31'b0, ram_rena_o}, 32'd0);
        check("rmw_wena", {31'b0, ram_wena_o}, 32'd1);
        check("rmw_waddr", ram_waddr_o, 32'h10);
        check("rmw_wdata", ram_wdata_o, 32'h1122AB44);
        tick();
        exp_q.push_back(32'h1122AB44);
        @(negedge clk_100MHz);
        check("held_lw_ready", {31'b0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
        tick();
        check("sb_ram", mem[4], 32'h1122AB44);

        // SW then LW back-to-back, no stall
        drive(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
        @(negedge clk_100MHz);
        check("sw_wena", {31'b0, ram_wena_o}, 32'd1);
        check("sw_waddr", ram_waddr_o, 32'h20);
        check("sw_wdata", ram_wdata_o, 32'hDEADBEEF);
        check("sw_rena", {31'b0, ram_rena_o}, 32'd0);
        tick();
        drive(1'b0, 3'b010, 32'h20, 32'h0);
        exp_q.push_back(32'hDEADBEEF);
        @(negedge clk_100MHz);
        check("lw_nostall", {31'b0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
        tick();

        // misaligned SH
        drive(1'b1, 3'b001, 32'h21, 32'h00005566);
`ifdef LSU_MISALIGN_TRAP_EN
        exp_w8 = 32'hDEADBEEF;
        @(negedge clk_100MHz);
        check("mis_rena", {31'b0, ram_rena_o}, 32'd0);
        check("mis_wena", {31'b0, ram_wena_o}, 32'd0);
        tick();
        req_valid_i = 1'b0;
        check("mis_pulse", {31'b0, misalign_o}, 32'd1);
        check("mis_badaddr", badaddr_o, 32'h21);
        check("mis_load_valid", {31'b0, load_valid_o}, 32'd0);
        tick();
        check("mis_pulse_end", {31'b0, misalign_o}, 32'd0);
`else
        exp_w8 = 32'hDEAD5566;
        @(negedge clk_100MHz);
        check("mis_rena", {31'b0, ram_rena_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
        check("mis_tied", {31'b0, misalign_o}, 32'd0);
        @(negedge clk_100MHz);
        check("mis_wena", {31'b0, ram_wena_o}, 32'd1);
        check("mis_waddr", ram_waddr_o, 32'h20);
        check("mis_wdata", ram_wdata_o, 32'hDEAD5566);
        tick();
`endif
        tick();
        check("mis_ram", mem[8], exp_w8);

        // reset during the RMW write cycle aborts the write
        drive(1'b1, 3'b001, 32'h22, 32'h00007777);
        tick();
        req_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk_100MHz);
        check("abort_wena", {31'b0, ram_wena_o}, 32'd0);
        check("abort_ready", {31'b0, req_ready_o}, 32'd0);
        tick();
        rst = 1'b0;
        check("abort_ram", mem[8], exp_w8);
        @(negedge clk_100MHz);
        check("abort_ready_after", {31'b0, req_ready_o}, 32'd1);
        check("abort_load_data", load_data_o, 32'd0);
        check("abort_load_valid", {31'b0, load_valid_o}, 32'd0);
        check("abort_misalign", {31'b0, misalign_o}, 32'd0);
        tick();

        // unused funct3 is a silent no-op for loads and stores
        for (int w = 0; w < 2; w++) begin
            drive(w[0], 3'b011, 32'h10, 32'h12345678);
            @(negedge clk_100MHz);
            check("nop_rena", {31'b0, ram_rena_o}, 32'd0);
            check("nop_wena", {31'b0, ram_wena_o}, 32'd0);
            tick();
            req_valid_i = 1'b0;
            check("nop_load_valid", {31'b0, load_valid_o}, 32'd0);
            check("nop_misalign", {31'b0, misalign_o}, 32'd0);
        end
        check("nop_ram", mem[4], 32'h1122AB44);

        tick(); tick();
        check("final_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
